// File: rtl/word_unpacker_if.sv
// Capture/stream signal bundle for word_unpacker; the abort input exists only
// when WORD_UNPACKER_ABORT_EN is defined.
interface word_unpacker_if #(
  parameter int ELEM_WIDTH = 32,
  parameter int NUM_ELEMS  = 8
);
  localparam int CNT_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [ELEM_WIDTH*NUM_ELEMS-1:0] in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [ELEM_WIDTH-1:0]           out_data;
  logic [CNT_W-1:0]                out_index;
  logic                            out_last;
  logic                            busy;
`ifdef WORD_UNPACKER_ABORT_EN
  logic                            abort;

  modport slave (
    input  in_valid, in_data, out_ready, abort,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );
  modport master (
    output in_valid, in_data, out_ready, abort,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, busy
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, busy
  );
`endif
endinterface

// File: rtl/word_unpacker.sv
// Captures one packed word and streams it out element by element with index/last.
// Optional early termination input enabled by defining WORD_UNPACKER_ABORT_EN.
module word_unpacker #(
  parameter int ELEM_WIDTH = 32,
  parameter int NUM_ELEMS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  word_unpacker_if.slave  bus
);
  localparam int CNT_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEMS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                index_q, index_d;
  logic [ELEM_WIDTH*NUM_ELEMS-1:0] word_q;
  logic                            accept;
  logic [ELEM_WIDTH-1:0]           elem [NUM_ELEMS];

  // Element view of the held word, addressed by the stream index.
  for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem
    assign elem[gi] = word_q[gi*ELEM_WIDTH +: ELEM_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (accept) begin
        word_q <= bus.in_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          index_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
`ifdef WORD_UNPACKER_ABORT_EN
        if (bus.abort) begin
          index_d = '0;
          state_d = IDLE;
        end else
`endif
        if (bus.out_ready) begin
          // Returning to IDLE after the last element leaves a one-cycle bubble.
          if (index_q == LAST_IDX) begin
            index_d = '0;
            state_d = IDLE;
          end else begin
            index_d = index_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  // Handshake outputs are held low for as long as reset is asserted.
  assign bus.in_ready  = !rst && (state_q == IDLE);
  assign bus.out_valid = !rst && (state_q == STREAM);
  assign bus.busy      = !rst && (state_q == STREAM);
  assign bus.out_last  = bus.out_valid && (index_q == LAST_IDX);
  assign bus.out_index = index_q;
  assign bus.out_data  = elem[index_q];
endmodule

// File: tb/tb_word_unpacker.sv
// Random and directed stimulus for word_unpacker, checked every cycle against a
// queue-of-elements model; a second instance covers the single-element case.
module tb_word_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  word_unpacker_if #(.ELEM_WIDTH(8), .NUM_ELEMS(4)) bus4();
  word_unpacker_if #(.ELEM_WIDTH(8), .NUM_ELEMS(1)) bus1();

  word_unpacker #(.ELEM_WIDTH(8), .NUM_ELEMS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  word_unpacker #(.ELEM_WIDTH(8), .NUM_ELEMS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } elem_t;
  elem_t mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pending elements of the current word; the head is what must be on the output.
  task automatic check_model();
    bit ev;
    int head_idx;
    ev       = !rst && (mq.size() != 0);
    head_idx = (mq.size() != 0) ? mq[0].idx : -1;
    chk("m_out_valid", 32'(bus4.out_valid), 32'(ev));
    chk("m_in_ready", 32'(bus4.in_ready), 32'(!rst && (mq.size() == 0)));
    chk("m_busy", 32'(bus4.busy), 32'(ev));
    chk("m_out_last", 32'(bus4.out_last), 32'(ev && (head_idx == 3)));
    if (ev) begin
      chk("m_out_data", 32'(bus4.out_data), 32'(mq[0].data));
      chk("m_out_index", 32'(bus4.out_index), 32'(head_idx));
    end
  endtask

  task automatic model_update();
    elem_t e;
    if (rst) begin
      mq.delete();
    end else if (mq.size() != 0) begin
`ifdef WORD_UNPACKER_ABORT_EN
      if (bus4.abort) mq.delete();
      else
`endif
      if (bus4.out_ready) void'(mq.pop_front());
    end else if (bus4.in_valid) begin
      for (int k = 0; k < 4; k++) begin
        e.data = bus4.in_data[k*8 +: 8];
        e.idx  = k;
        mq.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_elem(input string name, input logic [7:0] d, input int idx, input bit last);
    chk({name, "_valid"}, 32'(bus4.out_valid), 32'd1);
    chk({name, "_data"}, 32'(bus4.out_data), 32'(d));
    chk({name, "_index"}, 32'(bus4.out_index), 32'(idx));
    chk({name, "_last"}, 32'(bus4.out_last), 32'(last));
  endtask

  initial begin
    logic [31:0] w;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b1;
`ifdef WORD_UNPACKER_ABORT_EN
    bus4.abort = 1'b0;
    bus1.abort = 1'b0;
`endif
    tick();
    tick();
    chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus4.in_ready), 32'd0);
    chk("rst_busy", 32'(bus4.busy), 32'd0);

    // Basic stream
    rst = 1'b0;
    w = 32'h44332211;
    bus4.in_valid = 1'b1;
    bus4.in_data  = w;
    tick();
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_elem("t1", w[k*8 +: 8], k, k == 3);
      tick();
    end
    chk("t1_idle_in_ready", 32'(bus4.in_ready), 32'd1);
    chk("t1_idle_out_valid", 32'(bus4.out_valid), 32'd0);

    // Backpressure at index 1
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    bus4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_elem("t2_hold", 8'h22, 1, 1'b0);
      tick();
    end
    chk_elem("t2_hold", 8'h22, 1, 1'b0);
    bus4.out_ready = 1'b1;
    tick();
    chk_elem("t2_resume", 8'h33, 2, 1'b0);
    tick();
    tick();

    // Input held while busy
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_data = 32'hDDCCBBAA;
    tick();
    tick();
    tick();
    chk_elem("t3_first_last", 8'h44, 3, 1'b1);
    tick();
    chk("t3_bubble_valid", 32'(bus4.out_valid), 32'd0);
    chk("t3_bubble_ready", 32'(bus4.in_ready), 32'd1);
    tick();
    chk_elem("t3_second", 8'hAA, 0, 1'b0);
    bus4.in_valid = 1'b0;
    repeat (4) tick();

    // Reset mid-stream at index 2
    bus4.in_data  = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    tick();
    chk_elem("t4_pre", 8'h33, 2, 1'b0);
    rst = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(bus4.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t4_after_valid", 32'(bus4.out_valid), 32'd0);
    chk("t4_after_ready", 32'(bus4.in_ready), 32'd1);
    bus4.in_data  = 32'h0D0C0B0A;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    chk_elem("t4_new", 8'h0A, 0, 1'b0);
    repeat (4) tick();

`ifdef WORD_UNPACKER_ABORT_EN
    // Abort at index 1, then abort ignored during an IDLE capture
    bus4.in_data  = 32'h44332211;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    chk_elem("t5_pre", 8'h22, 1, 1'b0);
    bus4.abort = 1'b1;
    tick();
    chk("t5_abort_valid", 32'(bus4.out_valid), 32'd0);
    chk("t5_abort_ready", 32'(bus4.in_ready), 32'd1);
    bus4.in_valid = 1'b1;
    tick();
    bus4.abort    = 1'b0;
    bus4.in_valid = 1'b0;
    chk_elem("t5_idle_capture", 8'h11, 0, 1'b0);
    repeat (4) tick();
`endif

    // Single-element instance
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'h5A;
    tick();
    chk("t6_a_valid", 32'(bus1.out_valid), 32'd1);
    chk("t6_a_data", 32'(bus1.out_data), 32'h5A);
    chk("t6_a_last", 32'(bus1.out_last), 32'd1);
    chk("t6_a_index", 32'(bus1.out_index), 32'd0);
    bus1.in_data = 8'hA5;
    tick();
    chk("t6_gap_valid", 32'(bus1.out_valid), 32'd0);
    chk("t6_gap_ready", 32'(bus1.in_ready), 32'd1);
    tick();
    chk("t6_b_valid", 32'(bus1.out_valid), 32'd1);
    chk("t6_b_data", 32'(bus1.out_data), 32'hA5);
    chk("t6_b_last", 32'(bus1.out_last), 32'd1);
    chk("t6_b_index", 32'(bus1.out_index), 32'd0);
    bus1.in_valid = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 63) == 0);
      bus4.in_valid  = ($urandom_range(0, 2) != 0);
      bus4.in_data   = $urandom;
      bus4.out_ready = ($urandom_range(0, 3) != 0);
`ifdef WORD_UNPACKER_ABORT_EN
      bus4.abort = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
